// File: rtl/exec_mem_unit_pkg.sv
// Shared definitions for the execute/memory slice: ALU operation encodings.
package exec_mem_unit_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
endpackage

// File: rtl/cla_add32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained through
// group generate/propagate terms.
module cla_add32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_c;
  logic [7:0]  w_gp;
  logic [7:0]  w_gg;
  logic [8:0]  w_gc;

  assign w_p     = x ^ y;
  assign w_g     = x & y;
  assign w_gc[0] = cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    // Bit carries inside a group come straight from the group carry-in.
    assign w_c[B]   = w_gc[gi];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_gp[gi] = &w_p[B+3:B];
    assign w_gg[gi] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_gc[gi+1] = w_gg[gi] | (w_gp[gi] & w_gc[gi]);
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_gc[8];
endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: ALU with zero flag, branch-target adder and a
// word-addressed data memory (sync write, async read, async clear).
module exec_mem_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  aluc,
  input  logic [31:0] wdata,
  input  logic        wmem,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm_ext,
  output logic [31:0] r,
  output logic        z,
  output logic [31:0] dout,
  output logic [31:0] br_target,
  output logic        br_cout
);
  import exec_mem_unit_pkg::*;

  logic [31:0]   r_mem [DEPTH];
  logic          w_sub;
  logic [31:0]   w_b_op;
  logic [31:0]   w_addsub;
  logic          w_alu_cout;
  logic [AW-1:0] w_idx;
  logic          w_unused_bits;

  // Subtract reuses the adder as a + ~b + 1.
  assign w_sub  = (aluc == ALU_SUB);
  assign w_b_op = w_sub ? ~b : b;

  cla_add32 u_alu_add (
    .x    (a),
    .y    (w_b_op),
    .cin  (w_sub),
    .sum  (w_addsub),
    .cout (w_alu_cout)
  );

  cla_add32 u_br_add (
    .x    (pc_plus4),
    .y    ({imm_ext[29:0], 2'b00}),
    .cin  (1'b0),
    .sum  (br_target),
    .cout (br_cout)
  );

  always_comb begin
    r = '0;
    unique case (aluc)
      ALU_ADD, ALU_SUB: r = w_addsub;
      ALU_AND:          r = a & b;
      ALU_OR:           r = a | b;
      default:          r = '0;
    endcase
  end

  assign z = ~|r;

  // Byte offset and high address bits are dropped, so addresses alias.
  assign w_idx = r[AW+1:2];
  assign dout  = r_mem[w_idx];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wmem) begin
      r_mem[w_idx] <= wdata;
    end
  end

  assign w_unused_bits = &{1'b0, r[31:AW+2], r[1:0], imm_ext[31:30], w_alu_cout};
endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed + random bench for exec_mem_unit with an expected-value scoreboard.
module tb_exec_mem_unit;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] a, b, wdata, pc_plus4, imm_ext;
  logic [1:0]  aluc;
  logic        wmem;
  logic [31:0] r, dout, br_target;
  logic        z, br_cout;

  int vectors = 0;
  int miscompares = 0;

  localparam int SEL_R = 0, SEL_Z = 1, SEL_DOUT = 2, SEL_BT = 3, SEL_BC = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  exec_mem_unit #(.DEPTH(32), .AW(5)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .wdata     (wdata),
    .wmem      (wmem),
    .pc_plus4  (pc_plus4),
    .imm_ext   (imm_ext),
    .r         (r),
    .z         (z),
    .dout      (dout),
    .br_target (br_target),
    .br_cout   (br_cout)
  );

  always #5 Clk = ~Clk;

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t t;
    t.tag = tag;
    t.sel = sel;
    t.exp = e;
    sb.push_back(t);
  endtask

  // Let combinational outputs settle, then pop and compare every queued expectation.
  task automatic drain();
    #1;
    while (sb.size() > 0) begin
      exp_t        t;
      logic [31:0] o;
      t = sb.pop_front();
      case (t.sel)
        SEL_R:    o = r;
        SEL_Z:    o = {31'b0, z};
        SEL_DOUT: o = dout;
        SEL_BT:   o = br_target;
        default:  o = {31'b0, br_cout};
      endcase
      vectors++;
      assert (o === t.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t.tag, o, t.exp);
      end
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  task automatic alu_step(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez);
    aluc = op;
    a    = x;
    b    = y;
    push({tag, "_r"}, SEL_R, er);
    push({tag, "_z"}, SEL_Z, {31'b0, ez});
    drain();
  endtask

  task automatic br_step(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] et, input logic ec);
    pc_plus4 = pc;
    imm_ext  = imm;
    push({tag, "_tgt"}, SEL_BT, et);
    push({tag, "_cout"}, SEL_BC, {31'b0, ec});
    drain();
  endtask

  initial begin
    logic [32:0] bsum;
    logic [31:0] ra, rb, rpc, rimm, er;
    logic [1:0]  rop;

    Reset = 1'b0; a = 0; b = 0; aluc = 2'b00; wdata = 0; wmem = 0;
    pc_plus4 = 0; imm_ext = 0;
    #3;
    // Reset state: memory cleared at several addresses
    a = 32'd0;  push("rst_mem0", SEL_DOUT, 32'h0); drain();
    a = 32'd8;  push("rst_mem8", SEL_DOUT, 32'h0); drain();
    a = 32'h7C; push("rst_mem31", SEL_DOUT, 32'h0); drain();

    // ALU directed cases
    alu_step("add_5_3",   2'b00, 32'd5, 32'd3, 32'd8, 1'b0);
    alu_step("add_wrap",  2'b00, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1);
    alu_step("sub_eq",    2'b01, 32'd7, 32'd7, 32'h0, 1'b1);
    alu_step("sub_neg",   2'b01, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    alu_step("and",       2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    alu_step("or",        2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
    alu_step("and_zero",  2'b10, 32'hAAAAAAAA, 32'h55555555, 32'h0, 1'b1);
    alu_step("or_zero",   2'b11, 32'h0, 32'h0, 32'h0, 1'b1);
    alu_step("add_carry", 2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0);
    alu_step("sub_min",   2'b01, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      er  = alu_model(rop, ra, rb);
      alu_step($sformatf("alu_rand%0d", i), rop, ra, rb, er, (er == 32'h0));
    end

    // Branch target
    br_step("br_back", 32'h10, 32'hFFFFFFFE, 32'h8, 1'b1);
    br_step("br_fwd",  32'h4, 32'd3, 32'h10, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rpc  = $urandom;
      rimm = $urandom;
      bsum = {1'b0, rpc} + {1'b0, rimm[29:0], 2'b00};
      br_step($sformatf("br_rand%0d", i), rpc, rimm, bsum[31:0], bsum[32]);
    end

    // Memory write after reset release; old value visible until the edge
    @(negedge Clk);
    Reset = 1'b1;
    aluc = 2'b00; a = 32'd8; b = 32'd0; wdata = 32'hDEADBEEF; wmem = 1'b1;
    push("wr_before_edge", SEL_DOUT, 32'h0);
    drain();
    @(posedge Clk);
    push("wr_after_edge", SEL_DOUT, 32'hDEADBEEF);
    drain();
    @(negedge Clk);
    wmem = 1'b0;
    a = 32'h88; push("alias_88", SEL_DOUT, 32'hDEADBEEF); drain();
    a = 32'h0B; push("alias_0B", SEL_DOUT, 32'hDEADBEEF); drain();
    a = 32'd4;  push("word1_empty", SEL_DOUT, 32'h0); drain();

    // Second word, then overwrite of the first
    a = 32'd12; wdata = 32'h12345678; wmem = 1'b1;
    @(posedge Clk);
    push("wr_word3", SEL_DOUT, 32'h12345678);
    drain();
    @(negedge Clk);
    a = 32'd8; wdata = 32'hCAFEF00D;
    push("ovr_before", SEL_DOUT, 32'hDEADBEEF);
    drain();
    @(posedge Clk);
    push("ovr_after", SEL_DOUT, 32'hCAFEF00D);
    drain();
    @(negedge Clk);
    wmem = 1'b0;
    a = 32'd12; push("word3_kept", SEL_DOUT, 32'h12345678); drain();

    // Asynchronous clear between edges, writes suppressed while held
    a = 32'd8;
    #1;
    Reset = 1'b0;
    push("async_clr8", SEL_DOUT, 32'h0);
    drain();
    a = 32'd12; push("async_clr12", SEL_DOUT, 32'h0); drain();
    a = 32'd8; wdata = 32'h5A5A5A5A; wmem = 1'b1;
    @(posedge Clk);
    push("wr_in_reset", SEL_DOUT, 32'h0);
    drain();
    @(posedge Clk);
    push("wr_in_reset2", SEL_DOUT, 32'h0);
    drain();

    // First write after release lands on the next edge
    @(negedge Clk);
    Reset = 1'b1;
    push("release_pre", SEL_DOUT, 32'h0);
    drain();
    @(posedge Clk);
    push("release_wr", SEL_DOUT, 32'h5A5A5A5A);
    drain();
    @(negedge Clk);
    wmem = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
